// File: rtl/rom_arb_pkg.sv
// ---------------------------------------------------------------------------
// rom_arb_pkg
// Shared definitions for the two-port burst read arbiter.
//   state_t : arbiter FSM states (IDLE, BURST)
//   PORT0/PORT1 : requester index constants used for owner/grant fields
// ---------------------------------------------------------------------------
package rom_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2
// Combinational two-input round-robin selector.
//   eligible[1:0] in  : per-port request eligibility
//   last_grant    in  : port that received the most recent grant
//   grant_valid   out : at least one port is eligible
//   grant_idx     out : port to grant (meaningful only with grant_valid)
// ---------------------------------------------------------------------------
module rr_pick2
    import rom_arb_pkg::*;
(
    input  logic [1:0] eligible,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

    // With both ports eligible the one that did not win last time is chosen,
    // so under continuous contention grants alternate.
    always_comb begin
        grant_valid = |eligible;
        grant_idx   = PORT0;
        if (eligible == 2'b11) begin
            grant_idx = ~last_grant;
        end else if (eligible[1]) begin
            grant_idx = PORT1;
        end
    end

endmodule

// File: rtl/rom_read_arbiter.sv
// ---------------------------------------------------------------------------
// rom_read_arbiter
// Shares one synchronous-read memory between two burst requesters.
//   clk, rst               : clock, asynchronous active-high reset
//   req0/1, addr0/1, len0/1: burst requests (len = words - 1)
//   ack0/1                 : one-cycle pulse, burst accepted
//   rvalid0/1, rlast0/1    : per-port return word valid / final word
//   rdata                  : shared return data (wired from mem_data)
//   mem_addr, mem_data     : memory address out, registered read data in
// ---------------------------------------------------------------------------
module rom_read_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 8
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [LEN_WIDTH-1:0]  len0,
    input  logic [LEN_WIDTH-1:0]  len1,
    output logic                  ack0,
    output logic                  ack1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic                  rlast0,
    output logic                  rlast1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data
);

    state_t                state;
    logic                  owner;
    logic [LEN_WIDTH-1:0]  cnt;
    logic                  last_grant;
    logic                  pv;
    logic                  pl;
    logic                  pown;

    logic [1:0]            eligible;
    logic                  grant_valid;
    logic                  grant_idx;
    logic                  arb_edge;

    // A port whose ack is still high is mid-handshake; its req on this edge
    // belongs to the request just accepted and must not be granted again.
    assign eligible = {req1 & ~ack1, req0 & ~ack0};

    // Arbitration happens when idle or on the final address cycle of a burst,
    // which lets the next burst follow with no bubble.
    assign arb_edge = (state == IDLE) || (cnt == '0);

    rr_pick2 u_pick (
        .eligible    (eligible),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Burst FSM, address counter and response pipeline. The pipeline stage
    // tracks the one-cycle memory read latency so the valid/last/owner tags
    // line up with the word appearing on mem_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= PORT0;
            cnt        <= '0;
            last_grant <= PORT1;
            mem_addr   <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            pv         <= 1'b0;
            pl         <= 1'b0;
            pown       <= PORT0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;

            if (state == BURST) begin
                pv   <= 1'b1;
                pown <= owner;
                pl   <= (cnt == '0);
            end else begin
                pv   <= 1'b0;
            end

            if (arb_edge) begin
                if (grant_valid) begin
                    state      <= BURST;
                    owner      <= grant_idx;
                    last_grant <= grant_idx;
                    if (grant_idx == PORT0) begin
                        mem_addr <= addr0;
                        cnt      <= len0;
                        ack0     <= 1'b1;
                    end else begin
                        mem_addr <= addr1;
                        cnt      <= len1;
                        ack1     <= 1'b1;
                    end
                end else begin
                    state <= IDLE;
                end
            end else begin
                mem_addr <= mem_addr + ADDR_WIDTH'(1);
                cnt      <= cnt - LEN_WIDTH'(1);
            end
        end
    end

    // Output decode: only the owner of the word in flight sees rvalid.
    assign rvalid0 = pv && (pown == PORT0);
    assign rvalid1 = pv && (pown == PORT1);
    assign rlast0  = rvalid0 && pl;
    assign rlast1  = rvalid1 && pl;
    assign rdata   = mem_data;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rom_read_arbiter
// Self-checking bench: requester tasks drive bursts, a reference model
// predicts grants and pushes expected words into a scoreboard, and a monitor
// compares every returned word and every ack against it.
// ---------------------------------------------------------------------------
module tb_rom_read_arbiter;

    typedef struct packed {
        logic        port;
        logic [15:0] data;
        logic        last;
    } exp_word_t;

    logic        clk;
    logic        rst;
    logic [1:0]  req_r;
    logic [15:0] addr_r [2];
    logic [7:0]  len_r  [2];
    logic [1:0]  ack_w;
    logic        rvalid0, rvalid1, rlast0, rlast1;
    logic [15:0] rdata;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;

    logic [15:0] mem [65536];

    int tests;
    int fails;
    int cyc;

    exp_word_t sb[$];
    logic [1:0] exp_ack;
    int  words_left;
    bit  model_last;

    int ack_cnt [2];
    int ack_cyc [2];
    int rv_cyc  [2];
    int rv_count;
    int first_rv;
    int last_rv;

    rom_read_arbiter #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (16),
        .LEN_WIDTH  (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req_r[0]),
        .req1     (req_r[1]),
        .addr0    (addr_r[0]),
        .addr1    (addr_r[1]),
        .len0     (len_r[0]),
        .len1     (len_r[1]),
        .ack0     (ack_w[0]),
        .ack1     (ack_w[1]),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .rlast0   (rlast0),
        .rlast1   (rlast1),
        .rdata    (rdata),
        .mem_addr (mem_addr),
        .mem_data (mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read memory: one registered read, data register reset to 0.
    always @(posedge clk or posedge rst) begin
        if (rst) mem_data <= '0;
        else     mem_data <= mem[mem_addr];
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    // Reference model: a burst of len+1 words occupies len+1 address slots;
    // a new grant is decided on the final slot of a burst or when idle.
    // Every grant expands into its expected words in the scoreboard.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sb.delete();
            exp_ack    = '0;
            words_left = 0;
            model_last = 1'b1;
        end else begin
            bit [1:0] elig;
            logic [1:0] new_ack;
            int g;
            elig    = req_r & ~exp_ack;
            new_ack = '0;
            g       = -1;
            if (words_left <= 1) begin
                if (elig == 2'b11)  g = model_last ? 0 : 1;
                else if (elig[0])   g = 0;
                else if (elig[1])   g = 1;
                if (g >= 0) begin
                    new_ack[g] = 1'b1;
                    model_last = g[0];
                    words_left = int'(len_r[g]) + 1;
                    for (int i = 0; i < words_left; i++) begin
                        exp_word_t e;
                        logic [15:0] a;
                        a      = addr_r[g] + 16'(i);
                        e.port = g[0];
                        e.data = mem[a];
                        e.last = (i == words_left - 1);
                        sb.push_back(e);
                    end
                end else begin
                    words_left = 0;
                end
            end else begin
                words_left = words_left - 1;
            end
            exp_ack = new_ack;
        end
    end

    // Monitor: compares acks each cycle and pops one expected word for each
    // word the DUT returns.
    always @(negedge clk) begin
        if (!rst) begin
            check_output("ack", {30'd0, ack_w}, {30'd0, exp_ack});
            for (int p = 0; p < 2; p++) begin
                if (ack_w[p]) begin
                    ack_cnt[p]++;
                    ack_cyc[p] = cyc;
                end
            end
            if (rvalid0 && rvalid1) begin
                check_output("rvalid_exclusive", 32'd1, 32'd0);
            end else if (rvalid0 || rvalid1) begin
                int p;
                p = rvalid1 ? 1 : 0;
                rv_cyc[p] = cyc;
                rv_count++;
                if (first_rv < 0) first_rv = cyc;
                last_rv = cyc;
                if (sb.size() == 0) begin
                    check_output("unexpected_rvalid", 32'd1, 32'd0);
                end else begin
                    exp_word_t e;
                    e = sb.pop_front();
                    check_output("rvalid_port", 32'(p), 32'(e.port));
                    check_output("rdata", 32'(rdata), 32'(e.data));
                    check_output("rlast", {30'd0, rlast1, rlast0},
                                 32'(e.last) << e.port);
                end
            end else begin
                check_output("rlast_idle", {30'd0, rlast1, rlast0}, 32'd0);
            end
        end
    end

    task automatic clear_stats();
        for (int p = 0; p < 2; p++) begin
            ack_cnt[p] = 0;
            ack_cyc[p] = -100;
            rv_cyc[p]  = -100;
        end
        rv_count = 0;
        first_rv = -1;
        last_rv  = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_r = '0;
        rst   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b0;
    endtask

    // Posts one burst request and waits for its ack; with hold the req stays
    // high through the ack cycle before being released.
    task automatic apply_stimulus(input int p, input logic [15:0] a,
                                  input logic [7:0] l, input bit hold);
        bit got;
        got = 1'b0;
        @(negedge clk);
        req_r[p]  = 1'b1;
        addr_r[p] = a;
        len_r[p]  = l;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ack_w[p]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check_output("ack_timeout", 32'd0, 32'd1);
        if (hold) @(negedge clk);
        req_r[p] = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        cyc   = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        req_r     = '0;
        addr_r[0] = '0;
        addr_r[1] = '0;
        len_r[0]  = '0;
        len_r[1]  = '0;
        clear_stats();
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check_output("reset_mem_addr", 32'(mem_addr), 32'd0);
        check_output("reset_ack", {30'd0, ack_w}, 32'd0);
        check_output("reset_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
        check_output("reset_rlast", {30'd0, rlast1, rlast0}, 32'd0);
        rst = 1'b0;

        // Single len=3 burst from 0x0010 with exact return timing
        $display("[TB] single burst");
        apply_stimulus(0, 16'h0010, 8'd3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_output("t1_rvalid0", 32'(rvalid0), 32'd1);
            check_output("t1_rvalid1", 32'(rvalid1), 32'd0);
            check_output("t1_rlast0", 32'(rlast0), 32'(i == 3));
            check_output("t1_rdata", 32'(rdata), 32'(mem[16'h0010 + 16'(i)]));
        end
        @(negedge clk);
        check_output("t1_rvalid0_end", 32'(rvalid0), 32'd0);

        // Simultaneous len=0 requests after reset: port 0 first
        $display("[TB] contention");
        do_reset();
        clear_stats();
        fork
            apply_stimulus(0, 16'h0100, 8'd0, 1'b0);
            apply_stimulus(1, 16'h0200, 8'd0, 1'b0);
        join
        repeat (3) @(negedge clk);
        check_output("t2_ack_order", 32'(ack_cyc[1] - ack_cyc[0]), 32'd1);
        check_output("t2_latency", 32'(rv_cyc[0] - ack_cyc[0]), 32'd1);
        check_output("t2_rv_order", 32'(rv_cyc[1] - rv_cyc[0]), 32'd1);

        // Continuous len=1 requests on both ports: alternating, no bubbles
        $display("[TB] continuous alternation");
        clear_stats();
        fork
            for (int k = 0; k < 6; k++) apply_stimulus(0, 16'(16'h1000 + 16'(k * 16)), 8'd1, 1'b0);
            for (int k = 0; k < 6; k++) apply_stimulus(1, 16'(16'h2000 + 16'(k * 16)), 8'd1, 1'b0);
        join
        repeat (5) @(negedge clk);
        check_output("t3_word_count", 32'(rv_count), 32'd24);
        check_output("t3_duty_span", 32'(last_rv - first_rv + 1), 32'd24);
        check_output("t3_acks0", 32'(ack_cnt[0]), 32'd6);
        check_output("t3_acks1", 32'(ack_cnt[1]), 32'd6);

        // Address wrap at the top of memory
        $display("[TB] address wrap");
        apply_stimulus(1, 16'hFFFE, 8'd3, 1'b0);
        check_output("t4_addr0", 32'(mem_addr), 32'h0000FFFE);
        @(negedge clk);
        check_output("t4_addr1", 32'(mem_addr), 32'h0000FFFF);
        @(negedge clk);
        check_output("t4_addr2", 32'(mem_addr), 32'h00000000);
        @(negedge clk);
        check_output("t4_addr3", 32'(mem_addr), 32'h00000001);
        repeat (4) @(negedge clk);

        // Reset during the second word of a len=7 burst
        $display("[TB] reset mid-burst");
        apply_stimulus(0, 16'h3000, 8'd7, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_output("t5_second_word", 32'(rvalid0), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_output("t5_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
        check_output("t5_rlast", {30'd0, rlast1, rlast0}, 32'd0);
        check_output("t5_ack", {30'd0, ack_w}, 32'd0);
        check_output("t5_mem_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_stats();
        repeat (12) @(negedge clk);
        check_output("t5_no_rvalid", 32'(rv_count), 32'd0);

        // req held high through its ack cycle: only one burst accepted
        $display("[TB] held request");
        clear_stats();
        apply_stimulus(0, 16'h4000, 8'd0, 1'b1);
        repeat (6) @(negedge clk);
        check_output("t6_ack_count", 32'(ack_cnt[0]), 32'd1);
        check_output("t6_word_count", 32'(rv_count), 32'd1);

        // Randomized traffic from both requesters
        $display("[TB] random traffic");
        fork
            for (int k = 0; k < 15; k++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                apply_stimulus(0, 16'($urandom), 8'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            end
            for (int k = 0; k < 15; k++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                apply_stimulus(1, 16'($urandom), 8'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            end
        join
        for (int i = 0; i < 50; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check_output("drain_scoreboard", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
